alien3_sprite: RTL and testbench

Sprite engine for the third alien row: turns the VGA scan coordinates into read addresses for the 31 x 27 Alien3 pixel ROM, takes back the ROM's registered 8-bit pixel, and outputs a pixel/draw pair aligned to the scan. It also moves the alien once every few frames in a side-to-side, step-down pattern until it lands. It sits between the VGA timing generator (upstream) and the Alien3 ROM (alongside), and feeds the colour mux (downstream).

---
 rtl/alien_pkg.sv | 17 +
 rtl/alien_mover.sv | 105 ++++++++++
 rtl/alien3_sprite.sv | 113 +++++++++++
 tb/tb_alien3_sprite.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// Constants and mover state encoding shared by every alien row.
package alien_pkg;

   localparam int          SPR_WIDTH  = 31;
   localparam int          SPR_HEIGHT = 27;
   localparam logic [7:0]  SPR_TRANSP = 8'h00;

   localparam int          SCR_X_MAX  = 639;
   localparam int          SCR_Y_LAND = 400;

   typedef enum logic [1:0] {
      ST_RIGHT = 2'd0,
      ST_LEFT  = 2'd1,
      ST_HALT  = 2'd2
   } mover_state_t;

endpackage

// File: rtl/alien_mover.sv
// Frame divider, side-to-side/step-down mover FSM and position registers for one alien row.
module alien_mover
   import alien_pkg::*;
#(
   parameter int A_WIDTH   = SPR_WIDTH,
   parameter int START_X   = 300,
   parameter int START_Y   = 100,
   parameter int STEP_X    = 2,
   parameter int STEP_Y    = 8,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = SCR_X_MAX,
   parameter int Y_LAND    = SCR_Y_LAND,
   parameter int FRAME_DIV = 2
) (
   input  logic       i_clk2,
   input  logic       i_rst,
   input  logic       i_frame,
   input  logic       i_enable,
   output logic [9:0] o_x,
   output logic [9:0] o_y,
   output logic       o_landed
);

   localparam int               CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
   localparam logic [10:0]      R_SPAN   = 11'(STEP_X + A_WIDTH - 1);
   localparam logic [10:0]      R_LIMIT  = 11'(X_MAX);
   localparam logic [10:0]      L_LIMIT  = 11'(X_MIN + STEP_X);
   localparam logic [10:0]      Y_LIMIT  = 11'(Y_LAND);

   mover_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       x_q, x_d, y_q, y_d;
   logic             landed_q, landed_d;
   logic             tick, move, drop;
   logic [10:0]      y_drop_ext;

   always_ff @(posedge i_clk2) begin
      if (i_rst) begin
         state_q  <= ST_RIGHT;
         cnt_q    <= '0;
         x_q      <= 10'(START_X);
         y_q      <= 10'(START_Y);
         landed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         landed_q <= landed_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      landed_d   = landed_q;
      drop       = 1'b0;
      y_drop_ext = {1'b0, y_q} + 11'(STEP_Y);

      // The divider freezes while disabled or halted, so a pause resumes mid-count.
      tick = i_frame && i_enable && (state_q != ST_HALT);
      move = tick && (cnt_q == CNT_LAST);
      if (tick) begin
         cnt_d = move ? '0 : cnt_q + CNT_W'(1);
      end

      if (move) begin
         case (state_q)
            ST_RIGHT: begin
               if (({1'b0, x_q} + R_SPAN) > R_LIMIT) begin
                  drop    = 1'b1;
                  state_d = ST_LEFT;
               end else begin
                  x_d = x_q + 10'(STEP_X);
               end
            end
            ST_LEFT: begin
               if ({1'b0, x_q} < L_LIMIT) begin
                  drop    = 1'b1;
                  state_d = ST_RIGHT;
               end else begin
                  x_d = x_q - 10'(STEP_X);
               end
            end
            default: ;
         endcase
      end

      if (drop) begin
         y_d = y_drop_ext[9:0];
         if (y_drop_ext >= Y_LIMIT) begin
            landed_d = 1'b1;
            state_d  = ST_HALT;
         end
      end
   end

   assign o_x      = x_q;
   assign o_y      = y_q;
   assign o_landed = landed_q;

endmodule

// File: rtl/alien3_sprite.sv
// Alien3 sprite engine: scan-to-ROM addressing, hit/pixel alignment pipeline and mover.
module alien3_sprite
   import alien_pkg::*;
#(
   parameter int         A_WIDTH   = SPR_WIDTH,
   parameter int         A_HEIGHT  = SPR_HEIGHT,
   parameter int         START_X   = 300,
   parameter int         START_Y   = 100,
   parameter int         STEP_X    = 2,
   parameter int         STEP_Y    = 8,
   parameter int         X_MIN     = 0,
   parameter int         X_MAX     = SCR_X_MAX,
   parameter int         Y_LAND    = SCR_Y_LAND,
   parameter int         FRAME_DIV = 2,
   parameter logic [7:0] TRANSP    = SPR_TRANSP
) (
   input  logic       i_clk2,
   input  logic       i_rst,
   input  logic [9:0] i_xc,
   input  logic [9:0] i_yc,
   input  logic       i_frame,
   input  logic       i_enable,
   output logic [9:0] o_A3addr,
   input  logic [7:0] i_A3data,
   output logic [7:0] o_A3pixel,
   output logic       o_A3draw,
   output logic [9:0] o_A3x,
   output logic [9:0] o_A3y,
   output logic       o_A3landed
);

   localparam logic signed [10:0] DX_LAST = 11'(A_WIDTH - 1);
   localparam logic signed [10:0] DY_LAST = 11'(A_HEIGHT - 1);

   // Row stride of 31 done as (dy<<5)-dy; differences are only meaningful on a hit.
   function automatic logic [9:0] rom_addr(input logic [9:0] dy, input logic [9:0] dx);
      return (dy << 5) - dy + dx;
   endfunction

   logic [9:0] x_pos, y_pos;

   alien_mover #(
      .A_WIDTH   (A_WIDTH),
      .START_X   (START_X),
      .START_Y   (START_Y),
      .STEP_X    (STEP_X),
      .STEP_Y    (STEP_Y),
      .X_MIN     (X_MIN),
      .X_MAX     (X_MAX),
      .Y_LAND    (Y_LAND),
      .FRAME_DIV (FRAME_DIV)
   ) u_mover (
      .i_clk2   (i_clk2),
      .i_rst    (i_rst),
      .i_frame  (i_frame),
      .i_enable (i_enable),
      .o_x      (x_pos),
      .o_y      (y_pos),
      .o_landed (o_A3landed)
   );

   assign o_A3x = x_pos;
   assign o_A3y = y_pos;

   // Stage p0: signed 11-bit offsets so the window compare cannot wrap.
   logic signed [10:0] dx_p0, dy_p0;
   logic [9:0]         addr_p0;
   logic               hit_p0;

   always_comb begin
      dx_p0   = $signed({1'b0, i_xc}) - $signed({1'b0, x_pos});
      dy_p0   = $signed({1'b0, i_yc}) - $signed({1'b0, y_pos});
      hit_p0  = (dx_p0 >= 11'sd0) && (dx_p0 <= DX_LAST) &&
                (dy_p0 >= 11'sd0) && (dy_p0 <= DY_LAST);
      addr_p0 = hit_p0 ? rom_addr(i_yc - y_pos, i_xc - x_pos) : 10'd0;
   end

   // Stage p1: address to the ROM, hit follows it.
   logic vld_p1;

   always_ff @(posedge i_clk2) begin
      if (i_rst) begin
         o_A3addr <= '0;
         vld_p1   <= 1'b0;
      end else begin
         o_A3addr <= addr_p0;
         vld_p1   <= hit_p0;
      end
   end

   // Stage p2: hit aligned with the ROM's registered pixel.
   logic vld_p2;

   always_ff @(posedge i_clk2) begin
      if (i_rst) begin
         vld_p2 <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
      end
   end

   // Stage p3: pixel/draw to the colour mux.
   always_ff @(posedge i_clk2) begin
      if (i_rst) begin
         o_A3pixel <= '0;
         o_A3draw  <= 1'b0;
      end else begin
         o_A3pixel <= vld_p2 ? i_A3data : 8'h00;
         o_A3draw  <= vld_p2 && (i_A3data != TRANSP);
      end
   end

endmodule

// File: tb/tb_alien3_sprite.sv
// Bench for alien3_sprite: scoreboarded scan stream plus mover, edge, landing and reset scenarios.
module tb_alien3_sprite;

   logic       clk = 1'b0;
   logic       rst, rst_e, rst_l;
   logic       frame_a, frame_e, frame_l, enable;
   logic [9:0] xc, yc;
   logic [7:0] rom_a;

   logic [9:0] addr_a, x_a, y_a, addr_e, x_e, y_e, addr_l, x_l, y_l;
   logic [7:0] pix_a, pix_e, pix_l;
   logic       draw_a, draw_e, draw_l, landed_a, landed_e, landed_l;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int draw_seen = 0;

   logic [7:0] mem [0:836];

   typedef struct { int due; logic [9:0] addr; } aexp_t;
   typedef struct { int due; logic [7:0] pix; logic draw; } pexp_t;
   aexp_t aq[$];
   pexp_t pq[$];
   aexp_t ae;
   pexp_t pe;

   always #20 clk = ~clk;

   alien3_sprite u_dut (
      .i_clk2(clk), .i_rst(rst), .i_xc(xc), .i_yc(yc), .i_frame(frame_a), .i_enable(enable),
      .o_A3addr(addr_a), .i_A3data(rom_a), .o_A3pixel(pix_a), .o_A3draw(draw_a),
      .o_A3x(x_a), .o_A3y(y_a), .o_A3landed(landed_a));

   alien3_sprite #(.START_X(607)) u_edge (
      .i_clk2(clk), .i_rst(rst_e), .i_xc(xc), .i_yc(yc), .i_frame(frame_e), .i_enable(enable),
      .o_A3addr(addr_e), .i_A3data(8'h00), .o_A3pixel(pix_e), .o_A3draw(draw_e),
      .o_A3x(x_e), .o_A3y(y_e), .o_A3landed(landed_e));

   alien3_sprite #(.START_Y(392)) u_land (
      .i_clk2(clk), .i_rst(rst_l), .i_xc(xc), .i_yc(yc), .i_frame(frame_l), .i_enable(enable),
      .o_A3addr(addr_l), .i_A3data(8'h00), .o_A3pixel(pix_l), .o_A3draw(draw_l),
      .o_A3x(x_l), .o_A3y(y_l), .o_A3landed(landed_l));

   // One-cycle registered ROM model for the main instance.
   always @(posedge clk) rom_a <= mem[addr_a];
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: entries are compared on the cycle they fall due.
   always @(negedge clk) begin
      if (draw_a === 1'b1) draw_seen++;
      if (aq.size() > 0 && aq[0].due == cyc) begin
         ae = aq.pop_front();
         n_checks++;
         if (addr_a !== ae.addr) begin
            n_fail++;
            $display("FAIL sb_addr cycle %0d: got %0d expected %0d", cyc, addr_a, ae.addr);
         end
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
         pe = pq.pop_front();
         n_checks++;
         if (pix_a !== pe.pix || draw_a !== pe.draw) begin
            n_fail++;
            $display("FAIL sb_pixel cycle %0d: got pix %0d draw %0b expected pix %0d draw %0b",
                     cyc, pix_a, draw_a, pe.pix, pe.draw);
         end
      end
   end

   task automatic drive(input int x, input int y, input bit push);
      int    a;
      bit    h;
      aexp_t ea;
      pexp_t ep;
      @(negedge clk);
      xc = 10'(x);
      yc = 10'(y);
      if (push) begin
         h = (x >= 300) && (x <= 330) && (y >= 100) && (y <= 126);
         a = h ? (y - 100) * 31 + (x - 300) : 0;
         ea.due  = cyc + 1;
         ea.addr = 10'(a);
         aq.push_back(ea);
         ep.due  = cyc + 3;
         ep.pix  = h ? mem[a] : 8'h00;
         ep.draw = h && (mem[a] != 8'h00);
         pq.push_back(ep);
      end
   endtask

   task automatic pulse(input int which);
      @(negedge clk);
      case (which)
         0:       frame_a = 1'b1;
         1:       frame_e = 1'b1;
         default: frame_l = 1'b1;
      endcase
      @(negedge clk);
      frame_a = 1'b0;
      frame_e = 1'b0;
      frame_l = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; rst_e = 1'b1; rst_l = 1'b1;
      frame_a = 1'b0; frame_e = 1'b0; frame_l = 1'b0;
      enable = 1'b1; xc = 10'd0; yc = 10'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (addr_a !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr_a); end
      n_checks++; if (pix_a !== 8'd0) begin n_fail++; $display("FAIL reset_pixel: got %0d expected 0", pix_a); end
      n_checks++; if (draw_a !== 1'b0) begin n_fail++; $display("FAIL reset_draw: got %0b expected 0", draw_a); end
      n_checks++; if (x_a !== 10'd300 || y_a !== 10'd100) begin n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (300,100)", x_a, y_a); end
      n_checks++; if (landed_a !== 1'b0) begin n_fail++; $display("FAIL reset_landed: got %0b expected 0", landed_a); end
      n_checks++; if (x_e !== 10'd607 || y_l !== 10'd392) begin n_fail++; $display("FAIL reset_params: got x_e %0d y_l %0d expected 607 392", x_e, y_l); end
      rst = 1'b0; rst_e = 1'b0; rst_l = 1'b0;
   endtask

   task automatic test_single;
      drive(300, 100, 1);
      repeat (4) drive(0, 0, 1);
   endtask

   task automatic test_corners;
      drive(330, 126, 1);
      drive(331, 100, 1);
      drive(299, 100, 1);
      drive(300, 99, 1);
      drive(300, 127, 1);
      drive(330, 100, 1);
      drive(300, 126, 1);
      drive(315, 113, 1);
      repeat (4) drive(0, 0, 1);
   endtask

   task automatic test_sweep;
      int exp_draws = 0;
      int start     = draw_seen;
      for (int y = 95; y <= 130; y++) begin
         for (int x = 295; x <= 335; x++) begin
            drive(x, y, 1);
            if (x >= 300 && x <= 330 && y >= 100 && y <= 126 && mem[(y - 100) * 31 + (x - 300)] != 8'h00)
               exp_draws++;
         end
      end
      repeat (6) drive(0, 0, 1);
      n_checks++;
      if (draw_seen - start !== exp_draws) begin
         n_fail++;
         $display("FAIL sweep_draw_count: got %0d expected %0d", draw_seen - start, exp_draws);
      end
   endtask

   task automatic test_reset_mid_hit;
      for (int i = 0; i < 6; i++) drive(304 + i, 100, 0);
      n_checks++; if (draw_a !== 1'b1) begin n_fail++; $display("FAIL hitrun_draw: got %0b expected 1", draw_a); end
      @(negedge clk); xc = 10'd304; rst = 1'b1;
      @(negedge clk); xc = 10'd305; rst = 1'b0;
      n_checks++; if (draw_a !== 1'b0 || pix_a !== 8'd0) begin n_fail++; $display("FAIL rst_hit_c1: got draw %0b pix %0d expected 0 0", draw_a, pix_a); end
      @(negedge clk); xc = 10'd306;
      n_checks++; if (draw_a !== 1'b0) begin n_fail++; $display("FAIL rst_hit_c2: got %0b expected 0", draw_a); end
      @(negedge clk); xc = 10'd307;
      n_checks++; if (draw_a !== 1'b0) begin n_fail++; $display("FAIL rst_hit_c3: got %0b expected 0", draw_a); end
      @(negedge clk); xc = 10'd0; yc = 10'd0;
      n_checks++; if (draw_a !== 1'b1 || pix_a !== mem[5]) begin n_fail++; $display("FAIL rst_hit_resume: got draw %0b pix %0d expected 1 %0d", draw_a, pix_a, mem[5]); end
      repeat (4) drive(0, 0, 0);
   endtask

   task automatic test_divider;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      enable = 1'b1;
      pulse(0);
      n_checks++; if (x_a !== 10'd300) begin n_fail++; $display("FAIL div_first: got %0d expected 300", x_a); end
      pulse(0);
      n_checks++; if (x_a !== 10'd302) begin n_fail++; $display("FAIL div_second: got %0d expected 302", x_a); end
      pulse(0); pulse(0);
      n_checks++; if (x_a !== 10'd304 || y_a !== 10'd100) begin n_fail++; $display("FAIL div_four: got (%0d,%0d) expected (304,100)", x_a, y_a); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      enable = 1'b0;
      repeat (4) pulse(0);
      n_checks++; if (x_a !== 10'd300) begin n_fail++; $display("FAIL div_disabled: got %0d expected 300", x_a); end
      enable = 1'b1; pulse(0);
      enable = 1'b0; repeat (3) pulse(0);
      enable = 1'b1; pulse(0);
      n_checks++; if (x_a !== 10'd302) begin n_fail++; $display("FAIL div_hold: got %0d expected 302", x_a); end
      pulse(0);
      @(negedge clk); rst = 1'b1; frame_a = 1'b1;
      @(negedge clk); rst = 1'b0; frame_a = 1'b0;
      n_checks++; if (x_a !== 10'd300) begin n_fail++; $display("FAIL rst_vs_frame: got %0d expected 300", x_a); end
      pulse(0);
      n_checks++; if (x_a !== 10'd300) begin n_fail++; $display("FAIL div_cleared: got %0d expected 300", x_a); end
      pulse(0);
      n_checks++; if (x_a !== 10'd302) begin n_fail++; $display("FAIL div_after_rst: got %0d expected 302", x_a); end
   endtask

   task automatic test_edge;
      enable = 1'b1;
      repeat (2) pulse(1);
      n_checks++; if (x_e !== 10'd609 || y_e !== 10'd100) begin n_fail++; $display("FAIL edge_m1: got (%0d,%0d) expected (609,100)", x_e, y_e); end
      repeat (2) pulse(1);
      n_checks++; if (x_e !== 10'd609 || y_e !== 10'd108) begin n_fail++; $display("FAIL edge_drop: got (%0d,%0d) expected (609,108)", x_e, y_e); end
      repeat (2) pulse(1);
      n_checks++; if (x_e !== 10'd607 || y_e !== 10'd108) begin n_fail++; $display("FAIL edge_left: got (%0d,%0d) expected (607,108)", x_e, y_e); end
      n_checks++; if (landed_e !== 1'b0) begin n_fail++; $display("FAIL edge_landed: got %0b expected 0", landed_e); end
   endtask

   task automatic test_land;
      enable = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (landed_l === 1'b1) break;
         pulse(2);
      end
      n_checks++; if (landed_l !== 1'b1) begin n_fail++; $display("FAIL land_flag: got %0b expected 1", landed_l); end
      n_checks++; if (x_l !== 10'd608 || y_l !== 10'd400) begin n_fail++; $display("FAIL land_pos: got (%0d,%0d) expected (608,400)", x_l, y_l); end
      repeat (4) pulse(2);
      n_checks++; if (x_l !== 10'd608 || y_l !== 10'd400 || landed_l !== 1'b1) begin n_fail++; $display("FAIL land_halt: got (%0d,%0d) landed %0b expected (608,400) 1", x_l, y_l, landed_l); end
      @(negedge clk); rst_l = 1'b1;
      @(negedge clk); rst_l = 1'b0;
      n_checks++; if (x_l !== 10'd300 || y_l !== 10'd392 || landed_l !== 1'b0) begin n_fail++; $display("FAIL land_reset: got (%0d,%0d) landed %0b expected (300,392) 0", x_l, y_l, landed_l); end
      repeat (2) pulse(2);
      n_checks++; if (x_l !== 10'd302) begin n_fail++; $display("FAIL land_resume: got %0d expected 302", x_l); end
   endtask

   initial begin
      for (int i = 0; i < 837; i++) mem[i] = ((i % 7) == 3) ? 8'h00 : 8'(i * 13 + 5);
      test_reset();
      test_single();
      test_corners();
      test_sweep();
      test_reset_mid_hit();
      test_divider();
      test_edge();
      test_land();
      repeat (2) @(negedge clk);
      if (aq.size() != 0 || pq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_leftover: got %0d/%0d entries expected 0", aq.size(), pq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
